debounce_hold: RTL and testbench

//   Multi-channel switch debouncer with an input synchroniser, two selectable

---
 rtl/debounce_hold.sv | 159 +++++++++++++++
 tb/tb_debounce_hold.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_hold.sv
// Multi-channel switch debouncer: synchroniser, lockout or integrating filter,
// and long-press / auto-repeat strobes. Every channel is an independent copy.
module debounce_hold #(
    parameter int WIDTH        = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int BOUNCE_LIMIT = 1024,
    parameter int MODE         = 0,
    parameter int HOLD_LIMIT   = 0,
    parameter int REPEAT_LIMIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switch_in,
    output logic [WIDTH-1:0] switch_out,
    output logic [WIDTH-1:0] switch_rise,
    output logic [WIDTH-1:0] switch_fall,
    output logic [WIDTH-1:0] switch_hold,
    output logic [WIDTH-1:0] switch_busy
);

    localparam int              BW          = $clog2(BOUNCE_LIMIT);
    localparam logic [BW-1:0]   BOUNCE_LAST = BW'(BOUNCE_LIMIT - 1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s_q;
            logic [BW-1:0]          cnt_reg, cnt_next;
            logic                   out_reg, out_next;
            logic                   rise_reg, rise_next;
            logic                   fall_reg, fall_next;
            logic                   busy_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], switch_in[gi]};
                end
            end

            assign s_q = sync_reg[SYNC_STAGES-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg  <= '0;
                    out_reg  <= 1'b0;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                    busy_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    out_reg  <= out_next;
                    rise_reg <= rise_next;
                    fall_reg <= fall_next;
                    busy_reg <= (cnt_next != '0);
                end
            end

            if (MODE == 0) begin : g_lockout
                // Accept the first differing sample, then ignore the input until the count expires.
                always_comb begin
                    cnt_next  = cnt_reg;
                    out_next  = out_reg;
                    rise_next = 1'b0;
                    fall_next = 1'b0;
                    if (cnt_reg == '0) begin
                        if (s_q != out_reg) begin
                            out_next  = s_q;
                            rise_next = s_q;
                            fall_next = ~s_q;
                            cnt_next  = BOUNCE_LAST;
                        end
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
            end else begin : g_integrate
                // Count consecutive differing samples; any agreeing sample restarts the count.
                always_comb begin
                    cnt_next  = cnt_reg;
                    out_next  = out_reg;
                    rise_next = 1'b0;
                    fall_next = 1'b0;
                    if (s_q == out_reg) begin
                        cnt_next = '0;
                    end else if (cnt_reg == BOUNCE_LAST) begin
                        out_next  = s_q;
                        rise_next = s_q;
                        fall_next = ~s_q;
                        cnt_next  = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            if (HOLD_LIMIT > 0) begin : g_hold
                localparam int            HOLD_MAX    = (HOLD_LIMIT > REPEAT_LIMIT) ? HOLD_LIMIT : REPEAT_LIMIT;
                localparam int            HW          = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
                localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_LIMIT - 1);
                localparam logic [HW-1:0] REPEAT_LAST = HW'((REPEAT_LIMIT > 0) ? REPEAT_LIMIT - 1 : 0);

                logic [HW-1:0] hcnt_reg, hcnt_next;
                logic          repeat_reg, repeat_next;
                logic          hold_reg, hold_next;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        hcnt_reg   <= '0;
                        repeat_reg <= 1'b0;
                        hold_reg   <= 1'b0;
                    end else begin
                        hcnt_reg   <= hcnt_next;
                        repeat_reg <= repeat_next;
                        hold_reg   <= hold_next;
                    end
                end

                // repeat_reg marks that the first strobe has fired; with no repeat period the count freezes there.
                always_comb begin
                    hcnt_next   = hcnt_reg;
                    repeat_next = repeat_reg;
                    hold_next   = 1'b0;
                    if (!out_reg) begin
                        hcnt_next   = '0;
                        repeat_next = 1'b0;
                    end else if (!repeat_reg) begin
                        if (hcnt_reg == HOLD_LAST) begin
                            hold_next   = 1'b1;
                            hcnt_next   = '0;
                            repeat_next = 1'b1;
                        end else begin
                            hcnt_next = hcnt_reg + 1'b1;
                        end
                    end else if (REPEAT_LIMIT > 0) begin
                        if (hcnt_reg == REPEAT_LAST) begin
                            hold_next = 1'b1;
                            hcnt_next = '0;
                        end else begin
                            hcnt_next = hcnt_reg + 1'b1;
                        end
                    end
                end

                assign switch_hold[gi] = hold_reg;
            end else begin : g_no_hold
                assign switch_hold[gi] = 1'b0;
            end

            assign switch_out[gi]  = out_reg;
            assign switch_rise[gi] = rise_reg;
            assign switch_fall[gi] = fall_reg;
            assign switch_busy[gi] = busy_reg;
        end
    endgenerate

endmodule

// File: tb/tb_debounce_hold.sv
// Directed bench for debounce_hold: lockout, integrate, hold/repeat, independence, reset, lockout-end edge.
module tb_debounce_hold;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw0, sw1, sw2;
    logic [3:0] out0, rise0, fall0, hold0, busy0;
    logic [3:0] out1, rise1, fall1, hold1, busy1;
    logic [3:0] out2, rise2, fall2, hold2, busy2;

    int total = 0;
    int bad   = 0;

    // dut0: lockout with repeat, dut1: integrate, dut2: lockout single hold strobe
    debounce_hold #(.WIDTH(4), .SYNC_STAGES(2), .BOUNCE_LIMIT(8), .MODE(0),
                    .HOLD_LIMIT(20), .REPEAT_LIMIT(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .switch_in(sw0), .switch_out(out0),
        .switch_rise(rise0), .switch_fall(fall0), .switch_hold(hold0), .switch_busy(busy0));

    debounce_hold #(.WIDTH(4), .SYNC_STAGES(2), .BOUNCE_LIMIT(8), .MODE(1),
                    .HOLD_LIMIT(20), .REPEAT_LIMIT(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .switch_in(sw1), .switch_out(out1),
        .switch_rise(rise1), .switch_fall(fall1), .switch_hold(hold1), .switch_busy(busy1));

    debounce_hold #(.WIDTH(4), .SYNC_STAGES(2), .BOUNCE_LIMIT(8), .MODE(0),
                    .HOLD_LIMIT(20), .REPEAT_LIMIT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .switch_in(sw2), .switch_out(out2),
        .switch_rise(rise2), .switch_fall(fall2), .switch_hold(hold2), .switch_busy(busy2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // After this returns we are in cycle n: outputs of cycle n are stable, inputs set now are sampled at edge n+1.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        total++;
        if ({out0, rise0, fall0, hold0, busy0} !== 20'h0) begin
            bad++;
            $display("FAIL reset_dut0 got=%h exp=0", {out0, rise0, fall0, hold0, busy0});
        end
        total++;
        if ({out1, rise1, fall1, hold1, busy1, out2, rise2, fall2, hold2, busy2} !== 40'h0) begin
            bad++;
            $display("FAIL reset_dut12 got=%h exp=0", {out1, rise1, fall1, hold1, busy1, out2, rise2, fall2, hold2, busy2});
        end
        rst_n = 1'b1;
        repeat (5) step();
        total++;
        if ({out0, busy0, out1, busy1, out2, busy2} !== 24'h0) begin
            bad++;
            $display("FAIL reset_idle got=%h exp=0", {out0, busy0, out1, busy1, out2, busy2});
        end
    endtask

    task automatic test_lockout_bounce;
        logic eo, er, eb;
        for (int c = 0; c <= 14; c++) begin
            step();
            eo = (c >= 3);
            er = (c == 3);
            eb = (c >= 3 && c <= 9);
            total++;
            if (out0[0] !== eo) begin bad++; $display("FAIL lock_out c=%0d got=%b exp=%b", c, out0[0], eo); end
            total++;
            if (rise0[0] !== er) begin bad++; $display("FAIL lock_rise c=%0d got=%b exp=%b", c, rise0[0], er); end
            total++;
            if (fall0[0] !== 1'b0) begin bad++; $display("FAIL lock_fall c=%0d got=%b exp=0", c, fall0[0]); end
            if (c != 10) begin
                total++;
                if (busy0[0] !== eb) begin bad++; $display("FAIL lock_busy c=%0d got=%b exp=%b", c, busy0[0], eb); end
            end
            sw0[0] = (c <= 5) ? (c % 2 == 0) : 1'b1;
        end
        sw0[0] = 1'b0;
        repeat (20) step();
        total++;
        if (out0[0] !== 1'b0) begin bad++; $display("FAIL lock_release got=%b exp=0", out0[0]); end
    endtask

    task automatic test_integrate;
        int glen [2] = '{5, 7};
        for (int g = 0; g < 2; g++) begin
            for (int c = 0; c <= 20; c++) begin
                step();
                total++;
                if ({out1[1], rise1[1], fall1[1]} !== 3'b000) begin
                    bad++;
                    $display("FAIL integ_glitch%0d c=%0d got=%b exp=000", glen[g], c, {out1[1], rise1[1], fall1[1]});
                end
                sw1[1] = (c < glen[g]);
            end
        end
        for (int c = 0; c <= 14; c++) begin
            step();
            total++;
            if ({out1[1], rise1[1], fall1[1]} !== {c >= 10, c == 10, 1'b0}) begin
                bad++;
                $display("FAIL integ_rise c=%0d got=%b exp=%b", c, {out1[1], rise1[1], fall1[1]}, {c >= 10, c == 10, 1'b0});
            end
            sw1[1] = 1'b1;
        end
        for (int c = 0; c <= 14; c++) begin
            step();
            total++;
            if ({out1[1], rise1[1], fall1[1]} !== {c < 10, 1'b0, c == 10}) begin
                bad++;
                $display("FAIL integ_fall c=%0d got=%b exp=%b", c, {out1[1], rise1[1], fall1[1]}, {c < 10, 1'b0, c == 10});
            end
            sw1[1] = 1'b0;
        end
    endtask

    task automatic test_hold;
        logic eh0, eh2;
        // Rise lands at T=3; input released at cycle 59, so fall at 62.
        for (int c = 0; c <= 70; c++) begin
            step();
            eh0 = (c == 23 || c == 33 || c == 43 || c == 53);
            eh2 = (c == 23);
            total++;
            if (hold0[2] !== eh0) begin bad++; $display("FAIL hold_repeat c=%0d got=%b exp=%b", c, hold0[2], eh0); end
            total++;
            if (hold2[2] !== eh2) begin bad++; $display("FAIL hold_single c=%0d got=%b exp=%b", c, hold2[2], eh2); end
            total++;
            if (fall0[2] !== (c == 62)) begin bad++; $display("FAIL hold_fall c=%0d got=%b exp=%b", c, fall0[2], c == 62); end
            sw0[2] = (c <= 58);
            sw2[2] = (c <= 58);
        end
        repeat (20) step();
        // Release at T+15: no hold strobe, fall after synchroniser latency.
        for (int c = 0; c <= 50; c++) begin
            step();
            total++;
            if ({hold0[2], hold2[2]} !== 2'b00) begin bad++; $display("FAIL hold_short c=%0d got=%b exp=00", c, {hold0[2], hold2[2]}); end
            total++;
            if ({out0[2], fall0[2]} !== {c >= 3 && c < 21, c == 21}) begin
                bad++;
                $display("FAIL hold_short_out c=%0d got=%b exp=%b", c, {out0[2], fall0[2]}, {c >= 3 && c < 21, c == 21});
            end
            sw0[2] = (c < 18);
            sw2[2] = (c < 18);
        end
        repeat (20) step();
    endtask

    task automatic test_independence;
        logic [31:0] pat [4];
        logic [3:0]  mo, mr, mf, mb;
        int          mcnt [4];
        logic        s;
        pat[0] = 32'hFFFF_FFD5;
        pat[1] = 32'h0000_FF0C;
        pat[2] = 32'hFFFF_FE00;
        pat[3] = 32'h3FFF_E003;
        mo = '0; mr = '0; mf = '0;
        for (int ch = 0; ch < 4; ch++) mcnt[ch] = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            for (int ch = 0; ch < 4; ch++) mb[ch] = (mcnt[ch] != 0);
            total++;
            if (out0 !== mo) begin bad++; $display("FAIL indep_out c=%0d got=%b exp=%b", c, out0, mo); end
            total++;
            if (rise0 !== mr) begin bad++; $display("FAIL indep_rise c=%0d got=%b exp=%b", c, rise0, mr); end
            total++;
            if (fall0 !== mf) begin bad++; $display("FAIL indep_fall c=%0d got=%b exp=%b", c, fall0, mf); end
            total++;
            if (busy0 !== mb) begin bad++; $display("FAIL indep_busy c=%0d got=%b exp=%b", c, busy0, mb); end
            for (int ch = 0; ch < 4; ch++) begin
                s = (c >= 2) ? pat[ch][(c - 2 > 31) ? 31 : c - 2] : 1'b0;
                mr[ch] = 1'b0;
                mf[ch] = 1'b0;
                if (mcnt[ch] == 0) begin
                    if (s != mo[ch]) begin
                        mo[ch]   = s;
                        mr[ch]   = s;
                        mf[ch]   = ~s;
                        mcnt[ch] = 7;
                    end
                end else begin
                    mcnt[ch] = mcnt[ch] - 1;
                end
                sw0[ch] = pat[ch][(c > 31) ? 31 : c];
            end
        end
        sw0 = '0;
        repeat (30) step();
    endtask

    task automatic test_async_reset;
        for (int c = 0; c <= 5; c++) begin
            step();
            if (c == 3) begin
                total++;
                if ({out0[0], rise0[0]} !== 2'b11) begin bad++; $display("FAIL rst_pre got=%b exp=11", {out0[0], rise0[0]}); end
            end
            sw0[0] = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({out0, rise0, fall0, busy0} !== 16'h0) begin
            bad++;
            $display("FAIL rst_async got=%h exp=0", {out0, rise0, fall0, busy0});
        end
        step();
        rst_n = 1'b1;
        for (int c = 7; c <= 12; c++) begin
            step();
            total++;
            if ({out0[0], rise0[0]} !== {c >= 9, c == 9}) begin
                bad++;
                $display("FAIL rst_rerise c=%0d got=%b exp=%b", c, {out0[0], rise0[0]}, {c >= 9, c == 9});
            end
        end
        sw0[0] = 1'b0;
        repeat (20) step();
    endtask

    task automatic test_lockout_end;
        // Low sample inside lockout is ignored.
        for (int c = 0; c <= 20; c++) begin
            step();
            total++;
            if ({out0[3], fall0[3]} !== {c >= 3, 1'b0}) begin
                bad++;
                $display("FAIL lend_ignore c=%0d got=%b exp=%b", c, {out0[3], fall0[3]}, {c >= 3, 1'b0});
            end
            sw0[3] = (c != 7);
        end
        sw0[3] = 1'b0;
        repeat (20) step();
        // Low sample arriving on the cycle the count reaches zero is taken at once.
        for (int c = 0; c <= 20; c++) begin
            step();
            total++;
            if ({out0[3], rise0[3], fall0[3]} !== {c >= 3 && c < 11, c == 3, c == 11}) begin
                bad++;
                $display("FAIL lend_accept c=%0d got=%b exp=%b", c, {out0[3], rise0[3], fall0[3]}, {c >= 3 && c < 11, c == 3, c == 11});
            end
            sw0[3] = (c < 8);
        end
        repeat (20) step();
    endtask

    initial begin
        rst_n = 1'b0;
        sw0 = '0;
        sw1 = '0;
        sw2 = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_lockout_bounce();
        test_integrate();
        test_hold();
        test_independence();
        test_async_reset();
        test_lockout_end();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
